// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment display path.
//   - Segment bit positions (a = bit 0 ... g = bit 6) and glyph width.
//   - Glyph constants SEG_0..SEG_F and SEG_BLANK, built from per-segment
//     on/off flags so each glyph reads as the list of lit segments a..g.
package seven_segment_pkg;

    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;
    localparam int SEG_W     = SEG_G_BIT + 1;

    function automatic logic [SEG_W-1:0] seg_glyph(
        input logic a, input logic b, input logic c, input logic d,
        input logic e, input logic f, input logic g
    );
        logic [SEG_W-1:0] r;
        r            = '0;
        r[SEG_A_BIT] = a;
        r[SEG_B_BIT] = b;
        r[SEG_C_BIT] = c;
        r[SEG_D_BIT] = d;
        r[SEG_E_BIT] = e;
        r[SEG_F_BIT] = f;
        r[SEG_G_BIT] = g;
        return r;
    endfunction

    //                                              a     b     c     d     e     f     g
    localparam logic [SEG_W-1:0] SEG_0     = seg_glyph(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam logic [SEG_W-1:0] SEG_1     = seg_glyph(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam logic [SEG_W-1:0] SEG_2     = seg_glyph(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    localparam logic [SEG_W-1:0] SEG_3     = seg_glyph(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    localparam logic [SEG_W-1:0] SEG_4     = seg_glyph(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    localparam logic [SEG_W-1:0] SEG_5     = seg_glyph(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    localparam logic [SEG_W-1:0] SEG_6     = seg_glyph(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam logic [SEG_W-1:0] SEG_7     = seg_glyph(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam logic [SEG_W-1:0] SEG_8     = seg_glyph(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam logic [SEG_W-1:0] SEG_9     = seg_glyph(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    localparam logic [SEG_W-1:0] SEG_A     = seg_glyph(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    localparam logic [SEG_W-1:0] SEG_B     = seg_glyph(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam logic [SEG_W-1:0] SEG_C     = seg_glyph(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam logic [SEG_W-1:0] SEG_D     = seg_glyph(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    localparam logic [SEG_W-1:0] SEG_E     = seg_glyph(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam logic [SEG_W-1:0] SEG_F     = seg_glyph(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    localparam logic [SEG_W-1:0] SEG_BLANK = '0;

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational nibble-to-glyph decoder.
//   nibble : 4-bit digit code
//   hex_en : 1 = codes 10..15 render as A b C d E F, 0 = they render blank
//   glyph  : active-high segments, bit 0 = a ... bit 6 = g
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             hex_en,
    output logic [SEG_W-1:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (nibble)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            4'd10:   glyph = hex_en ? SEG_A : SEG_BLANK;
            4'd11:   glyph = hex_en ? SEG_B : SEG_BLANK;
            4'd12:   glyph = hex_en ? SEG_C : SEG_BLANK;
            4'd13:   glyph = hex_en ? SEG_D : SEG_BLANK;
            4'd14:   glyph = hex_en ? SEG_E : SEG_BLANK;
            4'd15:   glyph = hex_en ? SEG_F : SEG_BLANK;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_mux.sv
// Multiplexed seven-segment driver for DIGITS digits.
//   clk, reset : single clock, synchronous active-high reset
//   load       : one-cycle strobe; counts/dp are captured into shadow
//                registers on the edge where load = 1 (no back-pressure,
//                the driver is always ready to take a new value)
//   counts     : packed digits, digit i at [4i+3:4i], digit 0 = least significant
//   dp         : decimal point per digit
//   blank_lz   : leading-zero blanking enable, used live every cycle
//   segments   : registered segments of the active digit (bit 0 = a)
//   dp_out     : registered decimal point of the active digit
//   digit_en   : registered one-hot digit select, off during the dead time
//   frame      : registered one-cycle pulse once per full scan
// ACTIVE_LOW inverts segments, dp_out and digit_en (not frame).
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 1000,
    parameter int DEADTIME   = 8,
    parameter int HEX        = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   counts,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [SEG_W-1:0]      segments,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame
);

    localparam int   PRE_W  = $clog2(PRESCALE);
    localparam int   IDX_W  = $clog2(DIGITS);
    localparam logic POL    = (ACTIVE_LOW != 0);
    localparam logic HEX_EN = (HEX != 0);

    logic [PRE_W-1:0]    pre_cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] sh_counts;
    logic [DIGITS-1:0]   sh_dp;
    logic                wrap_seen;

    logic                slot_end;
    logic                scan_wrap;
    logic [DIGITS-1:0]   keep;
    logic                any_nz;
    logic [3:0]          cur_nibble;
    logic                cur_dp;
    logic                cur_keep;
    logic [DIGITS-1:0]   sel;
    logic                en_ok;
    logic [SEG_W-1:0]    glyph;
    logic [SEG_W-1:0]    seg_raw;

    assign slot_end  = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign scan_wrap = slot_end && (idx == IDX_W'(DIGITS - 1));

    // Digit enables stay off for the first DEADTIME cycles of each slot so
    // the previous digit's segment pattern never ghosts onto the next one.
    if (DEADTIME == 0) begin : g_no_dead
        assign en_ok = 1'b1;
    end else begin : g_dead
        assign en_ok = (pre_cnt >= PRE_W'(DEADTIME));
    end

    always_comb begin
        // keep[i] = some shadow digit at position i or above is nonzero
        // (suffix-OR); a digit with keep = 0 is a leading zero.
        any_nz = 1'b0;
        keep   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz  = any_nz | (|sh_counts[4*i +: 4]);
            keep[i] = any_nz;
        end
        keep[0] = 1'b1;

        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_keep   = 1'b0;
        sel        = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nibble = sh_counts[4*i +: 4];
                cur_dp     = sh_dp[i];
                cur_keep   = keep[i];
                sel[i]     = 1'b1;
            end
        end
    end

    seven_segment_decode u_decode (
        .nibble (cur_nibble),
        .hex_en (HEX_EN),
        .glyph  (glyph)
    );

    assign seg_raw = (blank_lz && !cur_keep) ? SEG_BLANK : glyph;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt   <= '0;
            idx       <= '0;
            sh_counts <= '0;
            sh_dp     <= '0;
            wrap_seen <= 1'b0;
            segments  <= {SEG_W{POL}};
            dp_out    <= POL;
            digit_en  <= {DIGITS{POL}};
            frame     <= 1'b0;
        end else begin
            if (slot_end) begin
                pre_cnt <= '0;
                idx     <= scan_wrap ? '0 : idx + IDX_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end

            if (load) begin
                sh_counts <= counts;
                sh_dp     <= dp;
            end

            // Outputs lag the slot state by one edge, so frame is delayed
            // one extra stage to line up with the first output cycle of
            // digit 0 after a wrap (and not with the post-reset start).
            wrap_seen <= scan_wrap;
            frame     <= wrap_seen;

            segments  <= seg_raw ^ {SEG_W{POL}};
            dp_out    <= cur_dp ^ POL;
            digit_en  <= (en_ok ? sel : '0) ^ {DIGITS{POL}};
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int DEADTIME = 1;
    localparam int OUT_W    = 13;          // {segments, dp_out, digit_en, frame}
    localparam int EXP_W    = 3 * OUT_W;   // base, hex, active-low instances

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 reset;
    logic                 load;
    logic [4*DIGITS-1:0]  counts;
    logic [DIGITS-1:0]    dp;
    logic                 blank_lz;

    logic [6:0]           seg_b, seg_h, seg_a;
    logic                 dp_b, dp_h, dp_a;
    logic [DIGITS-1:0]    en_b, en_h, en_a;
    logic                 fr_b, fr_h, fr_a;

    always #5 clk = ~clk;

    seven_segment_mux #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEADTIME(DEADTIME),
                        .HEX(0), .ACTIVE_LOW(0)) u_base (
        .clk(clk), .reset(reset), .load(load), .counts(counts), .dp(dp),
        .blank_lz(blank_lz), .segments(seg_b), .dp_out(dp_b), .digit_en(en_b), .frame(fr_b)
    );

    seven_segment_mux #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEADTIME(DEADTIME),
                        .HEX(1), .ACTIVE_LOW(0)) u_hex (
        .clk(clk), .reset(reset), .load(load), .counts(counts), .dp(dp),
        .blank_lz(blank_lz), .segments(seg_h), .dp_out(dp_h), .digit_en(en_h), .frame(fr_h)
    );

    seven_segment_mux #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEADTIME(DEADTIME),
                        .HEX(0), .ACTIVE_LOW(1)) u_al (
        .clk(clk), .reset(reset), .load(load), .counts(counts), .dp(dp),
        .blank_lz(blank_lz), .segments(seg_a), .dp_out(dp_a), .digit_en(en_a), .frame(fr_a)
    );

    // ---------------- reference model ----------------
    // Glyphs written g..a exactly as the display table lists them.
    logic [6:0] glyph_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    int         t;              // edges since reset released
    logic [3:0] m_cnt [DIGITS];
    logic       m_dp  [DIGITS];

    logic [EXP_W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    function automatic logic [OUT_W-1:0] expect_out(input bit hex, input bit al,
                                                    input bit rst, input bit blz);
        logic [6:0]        seg;
        logic              dpo;
        logic [DIGITS-1:0] en;
        logic              fr;
        int                slot;
        int                phase;
        bit                zeros;
        seg = '0; dpo = 1'b0; en = '0; fr = 1'b0;
        if (!rst) begin
            slot  = (t / PRESCALE) % DIGITS;
            phase = t % PRESCALE;
            zeros = 1'b1;
            for (int j = slot; j < DIGITS; j++)
                if (m_cnt[j] != 4'd0) zeros = 1'b0;
            if (slot >= 1 && blz && zeros)
                seg = '0;
            else if (m_cnt[slot] <= 4'd9 || hex)
                seg = glyph_tab[m_cnt[slot]];
            else
                seg = '0;
            dpo = m_dp[slot];
            if (phase >= DEADTIME) en[slot] = 1'b1;
            fr  = (t > 0) && (t % (DIGITS * PRESCALE) == 0);
        end
        if (al) begin
            seg = ~seg;
            dpo = ~dpo;
            en  = ~en;
        end
        return {seg, dpo, en, fr};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit rst, input bit ld, input logic [15:0] c,
                         input logic [3:0] d, input bit blz);
        @(negedge clk);
        reset    = rst;
        load     = ld;
        counts   = c;
        dp       = d;
        blank_lz = blz;
        exp_q.push_back({expect_out(1'b0, 1'b0, rst, blz),
                         expect_out(1'b1, 1'b0, rst, blz),
                         expect_out(1'b0, 1'b1, rst, blz)});
        if (rst) begin
            t = 0;
            for (int i = 0; i < DIGITS; i++) begin
                m_cnt[i] = 4'd0;
                m_dp[i]  = 1'b0;
            end
        end else begin
            t++;
            if (ld) begin
                for (int i = 0; i < DIGITS; i++) begin
                    m_cnt[i] = c[4*i +: 4];
                    m_dp[i]  = d[i];
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit blz);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 16'h0000, 4'b0000, blz);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_inst(input string tag, input logic [OUT_W-1:0] e,
                              input logic [6:0] s, input logic d,
                              input logic [DIGITS-1:0] en, input logic f);
        check({tag, ".segments"}, 16'(s),  16'(e[12:6]));
        check({tag, ".dp_out"},   16'(d),  16'(e[5]));
        check({tag, ".digit_en"}, 16'(en), 16'(e[4:1]));
        check({tag, ".frame"},    16'(f),  16'(e[0]));
    endtask

    initial begin : monitor
        logic [EXP_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_inst("base", e[3*OUT_W-1:2*OUT_W], seg_b, dp_b, en_b, fr_b);
                check_inst("hex",  e[2*OUT_W-1:OUT_W],   seg_h, dp_h, en_h, fr_h);
                check_inst("alow", e[OUT_W-1:0],         seg_a, dp_a, en_a, fr_a);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [15:0] rc;
        logic [3:0]  rd;
        bit          blz;
        int          guard;

        reset = 1'b1; load = 1'b0; counts = '0; dp = '0; blank_lz = 1'b0;
        t = 0;
        for (int i = 0; i < DIGITS; i++) begin
            m_cnt[i] = 4'd0;
            m_dp[i]  = 1'b0;
        end

        // Reset, then free-run showing zeros.
        repeat (3) drive(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
        idle(40, 1'b0);

        // Leading-zero blanking on and off.
        drive(1'b0, 1'b1, 16'h0042, 4'b0000, 1'b1);
        idle(20, 1'b1);
        idle(20, 1'b0);

        // Hex code in digit 1.
        drive(1'b0, 1'b1, 16'h00A5, 4'b0000, 1'b1);
        idle(20, 1'b1);

        // Decimal point on a blanked digit.
        drive(1'b0, 1'b1, 16'h0000, 4'b0100, 1'b1);
        idle(20, 1'b1);

        // Reset in the middle of slot 2.
        guard = 0;
        while (!(((t / PRESCALE) % DIGITS) == 2 && (t % PRESCALE) == 1) && guard < 32) begin
            idle(1, 1'b1);
            guard++;
        end
        drive(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1);
        idle(24, 1'b1);

        // Randomized loads, blanking toggles and occasional resets.
        blz = 1'b1;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < DIGITS; i++)
                rc[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            rd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) blz = ~blz;
            if ($urandom_range(0, 99) == 0)
                drive(1'b1, 1'b0, rc, rd, blz);
            else
                drive(1'b0, ($urandom_range(0, 7) == 0), rc, rd, blz);
        end

        // Drain the scoreboard.
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Parametrised multiplexed seven-segment driver for N digits. It latches a packed BCD/hex value on `load` and scans one digit per slot at a prescaled rate. It supports leading-zero blanking, per-digit decimal points, optional hex glyphs, an anti-ghosting dead time and selectable output polarity. It sits between the counter/measurement logic and the board's multiplexed display pins, and replaces the fixed two-digit driver.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned, ≥2.
- `PRESCALE`, 1000: clock cycles per digit slot, ≥2.
- `DEADTIME`, 8: cycles at slot start with all digit enables inactive; 0 ≤ DEADTIME < PRESCALE.
- `HEX`, 0: 1 = decode 10–15 as A–F; 0 = codes 10–15 blank.
- `ACTIVE_LOW`, 0: 1 = invert `segments`, `dp_out` and `digit_en` at the output registers.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `load` in 1: capture `counts`/`dp` into shadow registers.
- `counts` in 4*DIGITS: digit i (0 = least significant) at `[4i+3:4i]`.
- `dp` in DIGITS: decimal point per digit.
- `blank_lz` in 1: enable leading-zero blanking (level, sampled every cycle).
- `segments` out 7: bit0 = a … bit6 = g, registered.
- `dp_out` out 1: decimal point for the active digit, registered.
- `digit_en` out DIGITS: one-hot digit select, registered.
- `frame` out 1: one-cycle pulse on each scan wrap, registered.

## Operation
- Prescale counter `pre_cnt` runs 0..PRESCALE-1. The slot index `idx` advances when `pre_cnt == PRESCALE-1`. `idx` wraps DIGITS-1 → 0.
- Shadow registers load on an edge where `load`=1 and otherwise hold. When `load` and the slot advance coincide, both take effect on the same edge.
- Output registers update every edge from the current `idx`, `pre_cnt` and shadow values:
  - `digit_en` = one-hot(`idx`) when `pre_cnt ≥ DEADTIME`, else all inactive.
  - `segments` = decode(shadow digit `idx`), or blank if that digit is suppressed.
  - `dp_out` = shadow `dp[idx]`. It is never suppressed by leading-zero blanking.
- Leading-zero suppression: digit i (i ≥ 1) is blanked when `blank_lz`=1 and shadow digits i..DIGITS-1 are all 0. Digit 0 is never suppressed.
- Decode, with bit order g..a:
  - Digits: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Hex (HEX=1 only): A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
  - Blank = 0000000.
- Polarity: `ACTIVE_LOW` inverts all three display outputs after the logic above. "Inactive" in this document means the post-polarity off level.
- `frame` = 1 for exactly the edge after `idx` wraps to 0.

## Timing
- Reset values:
  - `pre_cnt`=0, `idx`=0, shadow counts=0, shadow dp=0.
  - `segments`, `dp_out` and `digit_en` at the inactive level; `frame`=0.
- First active output is on the first edge after reset deasserts: digit 0, showing "0" once DEADTIME has elapsed.
- Load latency: `load` sampled at edge n, shadow valid after edge n, outputs reflect it after edge n+1.
- Slot length is exactly PRESCALE cycles. `digit_en` is active for the last PRESCALE−DEADTIME cycles of each slot. Full frame is DIGITS×PRESCALE cycles.
- `reset` mid-scan returns everything to reset values on that edge. No partial slot is resumed.
- `frame` period is DIGITS×PRESCALE cycles, one cycle wide.
- `blank_lz` changes take effect on the next edge, with no latching.

## Structure
- Package `seven_segment_pkg` holds:
  - the segment glyph constants SEG_0..SEG_F and SEG_BLANK;
  - the segment bit-index constants.
- Sub-module `seven_segment_decode`: combinational nibble + `hex_en` → 7-bit glyph, using the package constants.
- Top level holds the prescaler, slot counter, shadow registers, the leading-zero mask (a DIGITS-bit suffix-OR of nonzero flags) and the output registers.

## Test plan
Bench configuration: DIGITS=4, PRESCALE=4, DEADTIME=1, HEX=0, ACTIVE_LOW=0 unless stated.
- Reset, then hold 40 cycles: `digit_en` cycles 0001→0010→0100→1000, each active 3 of 4 cycles. `segments`=0111111 whenever active. `frame` pulses every 16 cycles.
- Load `counts`=16'h0042 with `blank_lz`=1: digits 3 and 2 blank (0000000), digit 1=1100110, digit 0=1011011. With `blank_lz`=0, digits 3 and 2 show 0111111.
- Load 16'h00A5 with HEX=0: digit 1 blank. With HEX=1: digit 1=1110111.
- Load `dp`=4'b0100 with `counts`=0, `blank_lz`=1: digit 2 `segments` blank but `dp_out`=1 during its slot.
- ACTIVE_LOW=1: after reset, `segments`=1111111, `digit_en`=1111, `dp_out`=1. Digit 0 is later selected as 1110 with `segments`=1000000.
- Assert `reset` mid-slot 2: the next edge gives reset values, and the scan restarts at digit 0 with a full PRESCALE slot.
